chdr_ramp_pkt_checker: RTL and testbench



---
 rtl/chdr_ramp_pkt_checker.sv | 124 ++++++++++++
 tb/tb_chdr_ramp_pkt_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chdr_ramp_pkt_checker.sv
// chdr_ramp_pkt_checker: checks CHDR ramp packets at a FIFO output, counts good/bad packets, settings-bus control and readback
module chdr_ramp_pkt_checker #(
  parameter int SR_BASE   = 0,
  parameter int SR_AWIDTH = 8
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  input  logic [63:0]          i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  input  logic [1:0]           rb_addr,
  output logic [63:0]          rb_data,
  output logic                 err_stb
);
  typedef enum logic [1:0] {HDR, TIME, PAYLOAD, DRAIN} state_t;
  state_t state, state_nxt;
  logic en, chk_sid, chk_seq, seq_vld, beat, done, clr, ht, bad_len, sid_err, seq_err, last_beat;
  logic [3:0] wr;
  logic [7:0] period, thr;
  logic [31:0] sid_exp, incr, pkt_count, err_count;
  logic [63:0] expv;
  logic [12:0] words, k, last_k;
  logic [11:0] last_seq, pkt_idx, beat_idx, idx;
  logic [15:0] last_len, last_err;
  logic [3:0] pkt_code, beat_code, code;
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{i_tdata[63:62], i_tdata[60]};
  assign wr = {set_stb && set_addr == SR_AWIDTH'(SR_BASE + 3), set_stb && set_addr == SR_AWIDTH'(SR_BASE + 2),
               set_stb && set_addr == SR_AWIDTH'(SR_BASE + 1), set_stb && set_addr == SR_AWIDTH'(SR_BASE)};
  assign clr = wr[0] && set_data[1];
  assign i_tready = en && thr == 8'd0;
  assign beat = i_tvalid && i_tready;
  assign done = beat && i_tlast;
  assign ht = i_tdata[61];
  assign words = i_tdata[47:35];
  assign bad_len = |i_tdata[34:32] || words < 13'd2 + {12'd0, ht};
  assign sid_err = chk_sid && i_tdata[31:0] != sid_exp;
  assign seq_err = chk_seq && seq_vld && i_tdata[59:48] != last_seq + 12'd1;
  assign last_beat = k == last_k;
  always_comb begin
    state_nxt = state;
    beat_code = 4'd0;
    beat_idx = 12'd0;
    if (beat)
      case (state)
        HDR: begin
          beat_code = bad_len ? 4'd6 : sid_err ? 4'd1 : seq_err ? 4'd2 : i_tlast ? 4'd4 : 4'd0;
          state_nxt = i_tlast ? HDR : bad_len ? DRAIN : ht ? TIME : PAYLOAD;
        end
        TIME: begin
          beat_code = i_tlast ? 4'd4 : 4'd0;
          state_nxt = i_tlast ? HDR : PAYLOAD;
        end
        PAYLOAD: begin
          beat_code = i_tdata != expv ? 4'd3 : i_tlast && !last_beat ? 4'd4 : !i_tlast && last_beat ? 4'd5 : 4'd0;
          beat_idx = k[11:0];
          state_nxt = i_tlast ? HDR : last_beat ? DRAIN : PAYLOAD;
        end
        default: state_nxt = i_tlast ? HDR : DRAIN;
      endcase
    code = pkt_code != 4'd0 ? pkt_code : beat_code;
    idx = pkt_code != 4'd0 ? pkt_idx : beat_idx;
  end
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      state <= HDR;
      {en, chk_sid, chk_seq, seq_vld, err_stb} <= '0;
      period <= '0;
      thr <= '0;
      sid_exp <= '0;
      incr <= 32'h100;
      pkt_count <= '0;
      err_count <= '0;
      expv <= '0;
      k <= '0;
      last_k <= '0;
      last_seq <= '0;
      last_len <= '0;
      last_err <= '0;
      pkt_code <= '0;
      pkt_idx <= '0;
      rb_data <= '0;
    end else begin
      state <= state_nxt;
      thr <= thr >= period ? 8'd0 : thr + 8'd1;
      err_stb <= done && code != 4'd0;
      if (wr[0]) {chk_seq, chk_sid, en} <= {set_data[3:2], set_data[0]};
      if (wr[1]) sid_exp <= set_data;
      if (wr[2]) incr <= set_data;
      if (wr[3]) period <= set_data[7:0];
      if (beat) begin
        k <= state == PAYLOAD ? k + 13'd1 : 13'd0;
        expv <= state == PAYLOAD ? expv + {32'd0, incr} : 64'd0;
        pkt_code <= done ? 4'd0 : code;
        pkt_idx <= done ? 12'd0 : idx;
      end
      if (beat && state == HDR) begin
        last_seq <= i_tdata[59:48];
        last_len <= i_tdata[47:32];
        last_k <= words - 13'd2 - {12'd0, ht};
        seq_vld <= 1'b1;
      end
      if (done) begin
        pkt_count <= pkt_count + 32'(pkt_count != '1);
        if (code != 4'd0) begin
          err_count <= err_count + 32'(err_count != '1);
          last_err <= {code, idx};
        end
      end
      if (clr) begin
        pkt_count <= '0;
        err_count <= '0;
        last_err <= '0;
        seq_vld <= 1'b0;
      end
      rb_data <= rb_addr == 2'd0 ? {32'd0, pkt_count} : rb_addr == 2'd1 ? {32'd0, err_count} :
                 rb_addr == 2'd2 ? {48'd0, last_err} : {36'd0, last_seq, last_len};
    end
  end
endmodule

// File: tb/tb_chdr_ramp_pkt_checker.sv
// tb_chdr_ramp_pkt_checker: directed and randomized CHDR ramp packets checked against a packet-level reference model
module tb_chdr_ramp_pkt_checker;
  localparam logic [31:0] SID = 32'h0001_0002;
  logic bus_clk = 1'b0, bus_rst_n = 1'b0;
  logic [63:0] i_tdata = '0;
  logic i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic set_stb = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic [1:0] rb_addr = '0;
  logic [63:0] rb_data;
  logic err_stb;
  int checks = 0, failures = 0, stb_seen = 0, stb_exp = 0;
  logic [63:0] pkt[$];
  logic [31:0] m_pkt, m_err, m_sid;
  logic [15:0] m_last_err, m_len;
  logic [11:0] m_seq;
  logic [63:0] m_incr;
  bit m_seq_vld, m_chk_sid, m_chk_seq;

  chdr_ramp_pkt_checker #(.SR_BASE(0), .SR_AWIDTH(8)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .rb_addr(rb_addr), .rb_data(rb_data), .err_stb(err_stb));

  always #5 bus_clk = ~bus_clk;
  always @(negedge bus_clk) if (err_stb === 1'b1) stb_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_pkt = 0; m_err = 0; m_sid = 0; m_last_err = 0; m_len = 0; m_seq = 0;
    m_incr = 64'h100; m_seq_vld = 0; m_chk_sid = 0; m_chk_seq = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a; set_data = d; set_stb = 1'b1;
    @(posedge bus_clk); #1;
    set_stb = 1'b0;
    if (a == 8'd0) begin
      m_chk_sid = d[2]; m_chk_seq = d[3];
      if (d[1]) begin m_pkt = 0; m_err = 0; m_last_err = 0; m_seq_vld = 0; end
    end
    if (a == 8'd1) m_sid = d;
    if (a == 8'd2) m_incr = {32'd0, d};
  endtask

  task automatic rd(input logic [1:0] a, output logic [63:0] v);
    rb_addr = a;
    repeat (2) @(posedge bus_clk);
    #1 v = rb_data;
  endtask

  task automatic build(input bit ht, input logic [11:0] seq, input int len, input logic [31:0] sid, input int p);
    pkt.delete();
    pkt.push_back({2'b00, ht, 1'b0, seq, len[15:0], sid});
    if (ht) pkt.push_back({$urandom, $urandom});
    for (int k = 0; k < p; k++) pkt.push_back(64'(k) * m_incr);
  endtask

  task automatic send_range(input int a, input int b);
    bit acc;
    int t;
    for (int i = a; i <= b; i++) begin
      i_tdata = pkt[i]; i_tlast = (i == pkt.size() - 1); i_tvalid = 1'b1;
      acc = 0; t = 0;
      while (!acc) begin
        @(negedge bus_clk) acc = i_tready;
        @(posedge bus_clk); #1;
        t++;
        if (!acc && t > 64) begin
          $display("FAIL tready_timeout observed=0 expected=1 beat=%0d", i);
          $fatal(1);
        end
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic model_pkt();
    logic [63:0] h;
    int nb, n, p, ht, code, idx;
    h = pkt[0]; nb = pkt.size(); ht = int'(h[61]);
    n = int'(h[47:32]) / 8 - 1 - ht;
    code = 0; idx = 0;
    if (h[34:32] != 0 || n < 1) code = 6;
    else if (m_chk_sid && h[31:0] != m_sid) code = 1;
    else if (m_chk_seq && m_seq_vld && h[59:48] != m_seq + 12'd1) code = 2;
    else if (nb == 1 || (ht == 1 && nb == 2)) code = 4;
    else begin
      p = nb - 1 - ht;
      for (int k = 0; k < p && k < n; k++)
        if (code == 0 && pkt[1 + ht + k] != 64'(k) * m_incr) begin code = 3; idx = k; end
      if (code == 0 && p < n) begin code = 4; idx = p - 1; end
      else if (code == 0 && p > n) begin code = 5; idx = n - 1; end
    end
    m_seq = h[59:48]; m_len = h[47:32]; m_seq_vld = 1;
    if (m_pkt != '1) m_pkt++;
    if (code != 0) begin
      if (m_err != '1) m_err++;
      m_last_err = {code[3:0], idx[11:0]};
      stb_exp++;
    end
  endtask

  task automatic send_pkt();
    send_range(0, pkt.size() - 1);
    model_pkt();
  endtask

  task automatic check_all(input string s);
    logic [63:0] v;
    repeat (3) @(posedge bus_clk);
    #1;
    rd(2'd0, v); chk({s, ".pkt_count"}, v, {32'd0, m_pkt});
    rd(2'd1, v); chk({s, ".err_count"}, v, {32'd0, m_err});
    rd(2'd2, v); chk({s, ".last_err"}, v, {48'd0, m_last_err});
    rd(2'd3, v); chk({s, ".seq_len"}, v, {36'd0, m_seq, m_len});
    chk({s, ".err_stb"}, 64'(stb_seen), 64'(stb_exp));
  endtask

  initial begin
    logic [63:0] v;
    logic [11:0] cur_seq;
    int cnt, n, f, p;
    bit ht;
    reset_model();
    repeat (3) @(posedge bus_clk);
    @(negedge bus_clk);
    chk("rst.tready", i_tready, 0);
    chk("rst.rb_data", rb_data, 0);
    chk("rst.err_stb", err_stb, 0);
    @(posedge bus_clk); #1;
    bus_rst_n = 1'b1;
    chk("tready_before_en", i_tready, 0);
    wr(8'd1, SID);
    wr(8'd0, 32'd13);
    chk("tready_after_en", i_tready, 1);
    for (int i = 0; i < 10; i++) begin
      build(0, 12'(i), 168, SID, 20);
      send_pkt();
    end
    check_all("ramp10");
    rd(2'd0, v); chk("ramp10.pkt_const", v, 64'd10);
    rd(2'd1, v); chk("ramp10.err_const", v, 64'd0);
    rd(2'd3, v); chk("ramp10.rb3_const", v, {36'd0, 12'd9, 16'd168});
    build(0, 12'd10, 136, SID, 16);
    pkt[8] = pkt[8] ^ 64'h1;
    send_pkt();
    check_all("corrupt");
    rd(2'd2, v); chk("corrupt.last_err_const", v, 64'h3007);
    chk("corrupt.stb_const", 64'(stb_seen), 64'd1);
    build(0, 12'd11, 136, SID, 12); send_pkt(); check_all("short");
    build(0, 12'd12, 136, SID, 20); send_pkt(); check_all("long");
    build(0, 12'd13, 136, SID, 16); send_pkt(); check_all("after_drain");
    build(0, 12'd14, 136, SID ^ 32'h1, 16); send_pkt(); check_all("bad_sid");
    build(0, 12'd15, 136, SID, 16); send_pkt();
    build(0, 12'd17, 136, SID, 16); send_pkt(); check_all("seq_jump");
    rd(2'd2, v); chk("seq_jump.code", v[15:12], 64'd2);
    wr(8'd0, 32'd15);
    build(0, 12'd100, 136, SID, 16); send_pkt(); check_all("clear");
    rd(2'd0, v); chk("clear.pkt_const", v, 64'd1);
    rd(2'd1, v); chk("clear.err_const", v, 64'd0);
    wr(8'd3, 32'd3);
    cnt = 0;
    repeat (40) @(negedge bus_clk) cnt += int'(i_tready);
    chk("tready_duty", 64'(cnt), 64'd10);
    #1;
    build(0, 12'd101, 8200, SID, 1024); send_pkt(); check_all("p3_1024");
    wr(8'd3, 32'd0);
    build(1, 12'd102, 144, SID, 16); send_pkt(); check_all("has_time");
    build(0, 12'd103, 140, SID, 16); send_pkt(); check_all("bad_len");
    rd(2'd2, v); chk("bad_len.code", v[15:12], 64'd6);
    build(0, 12'd104, 136, SID, 16);
    send_range(0, 5);
    wr(8'd0, 32'd12);
    @(negedge bus_clk) chk("disabled.tready", i_tready, 0);
    @(posedge bus_clk); #1;
    wr(8'd0, 32'd13);
    send_range(6, pkt.size() - 1);
    model_pkt();
    check_all("resume");
    cur_seq = 12'd105;
    repeat (12) begin
      wr(8'd2, $urandom);
      ht = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 24);
      f = $urandom_range(0, 4);
      p = f == 2 ? $urandom_range(0, n - 1) : f == 3 ? n + $urandom_range(1, 3) : n;
      if (f == 4) cur_seq += 12'd2;
      build(ht, cur_seq, 8 * (1 + int'(ht) + n), SID, p);
      if (f == 1) pkt[1 + int'(ht) + $urandom_range(0, n - 1)] ^= 64'h1 << $urandom_range(0, 63);
      send_pkt();
      check_all("rand");
      cur_seq += 12'd1;
    end
    build(0, cur_seq, 136, SID, 16);
    send_range(0, 3);
    bus_rst_n = 1'b0;
    repeat (2) @(posedge bus_clk);
    #1 bus_rst_n = 1'b1;
    reset_model();
    chk("mid_rst.tready", i_tready, 0);
    check_all("mid_rst");
    wr(8'd1, SID);
    wr(8'd0, 32'd13);
    build(0, 12'd7, 136, SID, 16); send_pkt(); check_all("post_rst");
    rd(2'd0, v); chk("post_rst.pkt_const", v, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
